// File: rtl/mem_response_unit_pkg.sv
// Shared types for the memory response unit: RAM handshake states, word type
// and the responder FSM encoding.
package mem_response_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DACC = 2'd1,
    S_IACC = 2'd2,
    S_DONE = 2'd3
  } mru_state_t;

  localparam int unsigned TIMEOUT_DEFAULT  = 32'd255;
  localparam word_t       ERR_WORD_DEFAULT = 32'hBAD1_BAD1;

endpackage

// File: rtl/mem_response_unit_if.sv
// Datapath request/response handshake plus the single-ported RAM bus.
// The responder uses the slave view; the datapath/RAM environment uses master.
interface mem_response_unit_if;
  import mem_response_unit_pkg::*;

  logic      imemREN;
  word_t     imemaddr;
  logic      dmemREN;
  logic      dmemWEN;
  word_t     dmemaddr;
  word_t     dmemstore;
  logic      ihit;
  word_t     imemload;
  logic      dhit;
  word_t     dmemload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      err;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ramstate,
    output ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ramstate,
    input  ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/mem_response_unit_watchdog.sv
// Access watchdog: counts cycles spent waiting on the RAM and flags the cycle in
// which the running count reaches TIMEOUT. The counter saturates and never wraps.
module mem_response_unit_watchdog #(
  parameter int unsigned TIMEOUT = 32'd255
) (
  input  logic CLK,
  input  logic RST,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned   CW    = (TIMEOUT < 32'd1) ? 32'd1 : $clog2(TIMEOUT + 32'd1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc_s;

  // Next count and expiry; expiry looks at the count including the current cycle.
  always_comb begin
    cnt_inc_s = (cnt_q == LIMIT) ? cnt_q : (cnt_q + ONE);
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_inc_s;
    end else begin
      cnt_d = cnt_q;
    end
    expired_o = en_i & (cnt_inc_s == LIMIT);
  end

  // Counter register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_response_unit.sv
// Memory response unit: arbitrates held instruction/data requests onto one RAM
// port (data first), waits for ACCESS/ERROR or a watchdog timeout, then returns
// a registered one-cycle ihit/dhit pulse with the load word.
module mem_response_unit
  import mem_response_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
  parameter word_t       ERR_WORD = ERR_WORD_DEFAULT
) (
  input logic                 CLK,
  input logic                 RST,
  mem_response_unit_if.slave  bus
);

  mru_state_t state_q, state_d;
  logic       ihit_q, ihit_d;
  logic       dhit_q, dhit_d;
  word_t      imemload_q, imemload_d;
  word_t      dmemload_q, dmemload_d;
  logic       ramREN_q, ramREN_d;
  logic       ramWEN_q, ramWEN_d;
  word_t      ramaddr_q, ramaddr_d;
  word_t      ramstore_q, ramstore_d;
  logic       err_q, err_d;
  logic       wd_en_s;
  logic       wd_clr_s;
  logic       wd_expired_s;

  mem_response_unit_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .CLK       (CLK),
    .RST       (RST),
    .en_i      (wd_en_s),
    .clr_i     (wd_clr_s),
    .expired_o (wd_expired_s)
  );

  // Next-state and next-output logic; the RAM enables double as the latched direction.
  always_comb begin
    state_d    = state_q;
    ihit_d     = 1'b0;
    dhit_d     = 1'b0;
    imemload_d = imemload_q;
    dmemload_d = dmemload_q;
    ramREN_d   = ramREN_q;
    ramWEN_d   = ramWEN_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    err_d      = err_q;
    wd_en_s    = 1'b0;
    wd_clr_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        wd_clr_s = 1'b1;
        if (bus.dmemREN | bus.dmemWEN) begin
          // A simultaneous read and write request is serviced as a write.
          state_d    = S_DACC;
          ramaddr_d  = bus.dmemaddr;
          ramstore_d = bus.dmemstore;
          ramWEN_d   = bus.dmemWEN;
          ramREN_d   = ~bus.dmemWEN;
        end else if (bus.imemREN) begin
          state_d   = S_IACC;
          ramaddr_d = bus.imemaddr;
          ramREN_d  = 1'b1;
          ramWEN_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DACC, S_IACC: begin
        wd_en_s = 1'b1;
        if (bus.ramstate == ACCESS) begin
          state_d  = S_DONE;
          ramREN_d = 1'b0;
          ramWEN_d = 1'b0;
          if (state_q == S_DACC) begin
            dhit_d     = 1'b1;
            dmemload_d = ramWEN_q ? 32'h0000_0000 : bus.ramload;
          end else begin
            ihit_d     = 1'b1;
            imemload_d = bus.ramload;
          end
        end else if ((bus.ramstate == ERROR) || wd_expired_s) begin
          state_d  = S_DONE;
          ramREN_d = 1'b0;
          ramWEN_d = 1'b0;
          err_d    = 1'b1;
          if (state_q == S_DACC) begin
            dhit_d     = 1'b1;
            dmemload_d = ERR_WORD;
          end else begin
            ihit_d     = 1'b1;
            imemload_d = ERR_WORD;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DONE: begin
        // Requests are not sampled here: the requester drops them on the hit edge.
        wd_clr_s = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        wd_clr_s = 1'b1;
        state_d  = S_IDLE;
        ramREN_d = 1'b0;
        ramWEN_d = 1'b0;
      end
    endcase
  end

  // FSM state and all registered outputs, synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      imemload_q <= 32'h0000_0000;
      dmemload_q <= 32'h0000_0000;
      ramREN_q   <= 1'b0;
      ramWEN_q   <= 1'b0;
      ramaddr_q  <= 32'h0000_0000;
      ramstore_q <= 32'h0000_0000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ihit_q     <= ihit_d;
      dhit_q     <= dhit_d;
      imemload_q <= imemload_d;
      dmemload_q <= dmemload_d;
      ramREN_q   <= ramREN_d;
      ramWEN_q   <= ramWEN_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      err_q      <= err_d;
    end
  end

  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.imemload = imemload_q;
  assign bus.dmemload = dmemload_q;
  assign bus.ramREN   = ramREN_q;
  assign bus.ramWEN   = ramWEN_q;
  assign bus.ramaddr  = ramaddr_q;
  assign bus.ramstore = ramstore_q;
  assign bus.err      = err_q;

endmodule
